or1k_bp_pht_ctrl: RTL and testbench

Sequencer and update scheduler for the gshare pattern history table (PHT) of 2-bit saturating counters, held in an external 1R1W RAM. After reset or on a flush request, it sweeps the table to weakly-taken, one entry per granted write. In normal operation it queues resolved-branch updates and performs read-modify-write: read the counter, saturate toward the outcome, write it back. The write port is shared, so each write waits for a grant. The block sits between branch resolution (update producer) and the PHT RAM; the predictor's lookup read path is outside this block.

---
 rtl/or1k_bp_pht_ctrl.sv | 172 +++++++++++++++++
 tb/tb_or1k_bp_pht_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/or1k_bp_pht_ctrl.sv
// Sweep/update sequencer for the gshare PHT of 2-bit saturating counters.
// Sweeps the table to weakly-taken, then performs queued read-modify-write updates.
module or1k_bp_pht_ctrl #(
  parameter int GSHARE_BITS_NUM = 10,
  parameter int UPD_FIFO_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  output logic                       init_busy_o,
  input  logic                       upd_valid_i,
  output logic                       upd_ready_o,
  input  logic [GSHARE_BITS_NUM-1:0] upd_idx_i,
  input  logic                       upd_taken_i,
  output logic                       pht_re_o,
  output logic [GSHARE_BITS_NUM-1:0] pht_raddr_o,
  input  logic [1:0]                 pht_rdata_i,
  output logic                       pht_we_o,
  output logic [GSHARE_BITS_NUM-1:0] pht_waddr_o,
  output logic [1:0]                 pht_wdata_o,
  input  logic                       pht_wgnt_i,
  output logic [7:0]                 drop_cnt_o
);

  localparam int AW = $clog2(UPD_FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(UPD_FIFO_DEPTH);
  localparam logic [GSHARE_BITS_NUM:0] LAST_IDX = {1'b0, {GSHARE_BITS_NUM{1'b1}}};
  localparam logic [GSHARE_BITS_NUM:0] IDX_ONE = {{GSHARE_BITS_NUM{1'b0}}, 1'b1};

  typedef enum logic {ST_SWEEP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [GSHARE_BITS_NUM:0]   sweep_idx_q, sweep_idx_d;

  logic [GSHARE_BITS_NUM-1:0] fifo_idx [UPD_FIFO_DEPTH];
  logic                       fifo_taken [UPD_FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]              fifo_cnt_q;

  logic                       w_valid_q, w_fresh_q, w_taken_q;
  logic [GSHARE_BITS_NUM-1:0] w_idx_q;
  logic [1:0]                 w_cnt_q;

  logic                       last_wr_valid_q;
  logic [GSHARE_BITS_NUM-1:0] last_wr_addr_q;
  logic [1:0]                 last_wr_data_q;
  logic [7:0]                 drop_cnt_q;

  logic       run, fifo_empty, fifo_full, push, pop, w_done;
  logic [1:0] cnt_src, w_wdata;
  logic [9:0] drop_sum;

  function automatic logic [1:0] sat_cnt(input logic [1:0] c, input logic taken);
    logic [1:0] r;
    if (taken) r = (c == 2'b11) ? 2'b11 : c + 2'b01;
    else       r = (c == 2'b00) ? 2'b00 : c - 2'b01;
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    case (state_q)
      ST_SWEEP: begin
        if (flush_i) begin
          sweep_idx_d = '0;
        end else if (pht_wgnt_i) begin
          sweep_idx_d = sweep_idx_q + IDX_ONE;
          if (sweep_idx_q == LAST_IDX) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          state_d     = ST_SWEEP;
          sweep_idx_d = '0;
        end
      end
      default: state_d = ST_SWEEP;
    endcase
  end

  // Update handshake: an update transfers in any cycle with upd_valid_i && upd_ready_o;
  // the producer holds idx/taken stable until then, ready never depends on valid.
  always_comb begin
    run        = (state_q == ST_RUN);
    fifo_empty = (fifo_cnt_q == '0);
    fifo_full  = (fifo_cnt_q == FULL_CNT);

    upd_ready_o = !rst && run && !fifo_full && !flush_i;
    push        = upd_valid_i && upd_ready_o;

    // A write completed last cycle to this index is newer than what the RAM returned.
    cnt_src = (last_wr_valid_q && (last_wr_addr_q == w_idx_q)) ? last_wr_data_q : pht_rdata_i;
    w_wdata = w_fresh_q ? sat_cnt(cnt_src, w_taken_q) : w_cnt_q;

    pht_we_o    = !rst && (run ? (w_valid_q && !flush_i) : 1'b1);
    pht_waddr_o = run ? w_idx_q : sweep_idx_q[GSHARE_BITS_NUM-1:0];
    pht_wdata_o = run ? w_wdata : 2'b10;
    w_done      = run && pht_we_o && pht_wgnt_i;

    pop         = !rst && run && !flush_i && !fifo_empty && (!w_valid_q || w_done);
    pht_re_o    = pop;
    pht_raddr_o = fifo_idx[rd_ptr_q];

    init_busy_o = rst || !run;
    drop_cnt_o  = drop_cnt_q;
    drop_sum    = {2'b00, drop_cnt_q} + 10'(fifo_cnt_q) + 10'(w_valid_q);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr_q]   <= upd_idx_i;
      fifo_taken[wr_ptr_q] <= upd_taken_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_SWEEP;
      sweep_idx_q     <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fifo_cnt_q      <= '0;
      w_valid_q       <= 1'b0;
      w_fresh_q       <= 1'b0;
      w_taken_q       <= 1'b0;
      w_idx_q         <= '0;
      w_cnt_q         <= '0;
      last_wr_valid_q <= 1'b0;
      last_wr_addr_q  <= '0;
      last_wr_data_q  <= '0;
      drop_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      sweep_idx_q     <= sweep_idx_d;
      last_wr_valid_q <= pht_we_o && pht_wgnt_i;
      last_wr_addr_q  <= pht_waddr_o;
      last_wr_data_q  <= pht_wdata_o;
      if (flush_i) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fifo_cnt_q <= '0;
        w_valid_q  <= 1'b0;
        w_fresh_q  <= 1'b0;
        drop_cnt_q <= (drop_sum > 10'd255) ? 8'd255 : drop_sum[7:0];
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        case ({push, pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
          2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
          default: fifo_cnt_q <= fifo_cnt_q;
        endcase
        if (pop) begin
          w_valid_q <= 1'b1;
          w_fresh_q <= 1'b1;
          w_idx_q   <= fifo_idx[rd_ptr_q];
          w_taken_q <= fifo_taken[rd_ptr_q];
        end else if (w_done) begin
          w_valid_q <= 1'b0;
          w_fresh_q <= 1'b0;
        end else if (w_fresh_q) begin
          // Freeze the result so the write request stays stable while stalled.
          w_fresh_q <= 1'b0;
          w_cnt_q   <= w_wdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_or1k_bp_pht_ctrl.sv
// Directed bench for or1k_bp_pht_ctrl with a 16-entry table and a behavioural 1R1W RAM.
module tb_or1k_bp_pht_ctrl;

  localparam int G = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush, upd_valid, upd_taken, gnt;
  logic [G-1:0] upd_idx;
  logic         init_busy, upd_ready, pht_re, pht_we;
  logic [G-1:0] pht_raddr, pht_waddr;
  logic [1:0]   pht_rdata, pht_wdata;
  logic [7:0]   drop_cnt;

  logic [1:0]   mem [16];
  logic [5:0]   exp_q[$];
  int           n_checks = 0;
  int           n_pass = 0;

  typedef struct {
    logic         v;
    logic [G-1:0] idx;
    logic         t;
    logic         e_re;
    logic [G-1:0] e_raddr;
    logic         e_we;
    logic [G-1:0] e_waddr;
    logic [1:0]   e_wdata;
  } vec_t;

  vec_t tbl[16];

  or1k_bp_pht_ctrl #(.GSHARE_BITS_NUM(G), .UPD_FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .init_busy_o(init_busy),
    .upd_valid_i(upd_valid), .upd_ready_o(upd_ready), .upd_idx_i(upd_idx),
    .upd_taken_i(upd_taken), .pht_re_o(pht_re), .pht_raddr_o(pht_raddr),
    .pht_rdata_i(pht_rdata), .pht_we_o(pht_we), .pht_waddr_o(pht_waddr),
    .pht_wdata_o(pht_wdata), .pht_wgnt_i(gnt), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  // RAM: registered read returning old data on a same-cycle same-address write.
  always @(posedge clk) begin
    if (pht_re) pht_rdata <= mem[pht_raddr];
    if (pht_we && gnt) mem[pht_waddr] <= pht_wdata;
  end

  function automatic logic [15:0] pk(input logic busy, input logic ready, input logic re,
                                     input logic [G-1:0] ra, input logic we,
                                     input logic [G-1:0] wa, input logic [1:0] wd);
    return {2'b00, busy, ready, re, (re ? ra : 4'h0), we, (we ? wa : 4'h0), (we ? wd : 2'b00)};
  endfunction

  function automatic vec_t mkv(input logic v, input logic [G-1:0] idx, input logic t,
                               input logic re, input logic [G-1:0] ra,
                               input logic we, input logic [G-1:0] wa, input logic [1:0] wd);
    vec_t r;
    r.v = v; r.idx = idx; r.t = t; r.e_re = re; r.e_raddr = ra;
    r.e_we = we; r.e_waddr = wa; r.e_wdata = wd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [15:0] outs();
    return pk(init_busy, upd_ready, pht_re, pht_raddr, pht_we, pht_waddr, pht_wdata);
  endfunction

  // One clock: drive after the edge, sample at the falling edge, score any completed write.
  task automatic cyc(input logic r, input logic v, input logic [G-1:0] i, input logic t,
                     input logic g, input logic f);
    logic [5:0] e;
    @(posedge clk);
    #1;
    rst = r; upd_valid = v; upd_idx = i; upd_taken = t; gnt = g; flush = f;
    @(negedge clk);
    if (pht_we && gnt) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {10'h0, pht_waddr, pht_wdata}, 16'hffff);
      end else begin
        e = exp_q.pop_front();
        chk("write_sb", {10'h0, pht_waddr, pht_wdata}, {10'h0, e});
      end
    end
  endtask

  task automatic push_sweep();
    for (int k = 0; k < 16; k++) exp_q.push_back({4'(k), 2'b10});
  endtask

  initial begin
    flush = 0; upd_valid = 0; upd_idx = '0; upd_taken = 0; gnt = 1;

    tbl[0]  = mkv(1, 5, 1, 0, 0, 0, 0, 2'b00);
    tbl[1]  = mkv(0, 0, 0, 1, 5, 0, 0, 2'b00);
    tbl[2]  = mkv(1, 5, 1, 0, 0, 1, 5, 2'b11);
    tbl[3]  = mkv(0, 0, 0, 1, 5, 0, 0, 2'b00);
    tbl[4]  = mkv(0, 0, 0, 0, 0, 1, 5, 2'b11);
    tbl[5]  = mkv(0, 0, 0, 0, 0, 0, 0, 2'b00);
    tbl[6]  = mkv(1, 3, 0, 0, 0, 0, 0, 2'b00);
    tbl[7]  = mkv(1, 3, 0, 1, 3, 0, 0, 2'b00);
    tbl[8]  = mkv(0, 0, 0, 1, 3, 1, 3, 2'b01);
    tbl[9]  = mkv(0, 0, 0, 0, 0, 1, 3, 2'b00);
    tbl[10] = mkv(0, 0, 0, 0, 0, 0, 0, 2'b00);
    tbl[11] = mkv(1, 7, 1, 0, 0, 0, 0, 2'b00);
    tbl[12] = mkv(1, 3, 1, 1, 7, 0, 0, 2'b00);
    tbl[13] = mkv(0, 0, 0, 1, 3, 1, 7, 2'b11);
    tbl[14] = mkv(0, 0, 0, 0, 0, 1, 3, 2'b01);
    tbl[15] = mkv(0, 0, 0, 0, 0, 0, 0, 2'b00);

    // Reset sweep with a constant grant.
    cyc(1, 0, 0, 0, 1, 0);
    chk("reset_outputs", outs(), pk(1, 0, 0, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 1, 0);
    chk("reset_drop", {8'h0, drop_cnt}, 16'h0);
    push_sweep();
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk($sformatf("sweep_gnt1_%0d", k), outs(), pk(1, 0, 0, 0, 1, 4'(k), 2'b10));
    end
    cyc(0, 0, 0, 0, 1, 0);
    chk("sweep_gnt1_done", outs(), pk(0, 1, 0, 0, 0, 0, 0));

    // Sweep again with a grant on every other cycle.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    push_sweep();
    for (int c = 0; c < 32; c++) begin
      cyc(0, 0, 0, 0, (c % 2 == 1), 0);
      chk($sformatf("sweep_tog_%0d", c), outs(), pk(1, 0, 0, 0, 1, 4'(c / 2), 2'b10));
    end
    cyc(0, 0, 0, 0, 1, 0);
    chk("sweep_tog_done", outs(), pk(0, 1, 0, 0, 0, 0, 0));

    // Single updates, back-to-back forwarding and interleaved indices, constant grant.
    for (int n = 0; n < 16; n++) begin
      if (tbl[n].e_we) exp_q.push_back({tbl[n].e_waddr, tbl[n].e_wdata});
      cyc(0, tbl[n].v, tbl[n].idx, tbl[n].t, 1, 0);
      chk($sformatf("vec_%0d", n), outs(),
          pk(0, 1, tbl[n].e_re, tbl[n].e_raddr, tbl[n].e_we, tbl[n].e_waddr, tbl[n].e_wdata));
    end
    chk("vec_drain", 16'(exp_q.size()), 16'h0);

    // Ten stalled cycles with six updates offered, then release.
    exp_q.push_back({4'd1, 2'b11}); exp_q.push_back({4'd1, 2'b11});
    exp_q.push_back({4'd2, 2'b01}); exp_q.push_back({4'd1, 2'b11});
    exp_q.push_back({4'd2, 2'b00}); exp_q.push_back({4'd9, 2'b01});
    cyc(0, 1, 1, 1, 0, 0);
    chk("stall_s0", outs(), pk(0, 1, 0, 0, 0, 0, 0));
    cyc(0, 1, 1, 1, 0, 0);
    chk("stall_s1", outs(), pk(0, 1, 1, 1, 0, 0, 0));
    for (int s = 2; s < 10; s++) begin
      case (s)
        2:       cyc(0, 1, 2, 0, 0, 0);
        3:       cyc(0, 1, 1, 1, 0, 0);
        4:       cyc(0, 1, 2, 0, 0, 0);
        default: cyc(0, 1, 9, 0, 0, 0);
      endcase
      chk($sformatf("stall_s%0d", s), outs(), pk(0, (s < 5), 0, 0, 1, 1, 2'b11));
    end
    cyc(0, 1, 9, 0, 1, 0);
    chk("stall_s10", outs(), pk(0, 0, 1, 1, 1, 1, 2'b11));
    cyc(0, 1, 9, 0, 1, 0);
    chk("stall_s11", outs(), pk(0, 1, 1, 2, 1, 1, 2'b11));
    for (int s = 12; s < 18; s++) cyc(0, 0, 0, 0, 1, 0);
    chk("stall_drain", 16'(exp_q.size()), 16'h0);

    // Flush with three queued updates and an occupied write stage.
    cyc(0, 1, 4, 1, 0, 0);
    cyc(0, 1, 4, 1, 0, 0);
    cyc(0, 1, 5, 1, 0, 0);
    cyc(0, 1, 6, 1, 0, 0);
    chk("pre_flush_drop", {8'h0, drop_cnt}, 16'h0);
    cyc(0, 0, 0, 0, 1, 1);
    chk("flush_cycle", outs(), pk(0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back({4'd0, 2'b10}); exp_q.push_back({4'd1, 2'b10});
    exp_q.push_back({4'd2, 2'b10});
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk($sformatf("flush_sweep_%0d", k), outs(), pk(1, 0, 0, 0, 1, 4'(k), 2'b10));
    end
    chk("flush_drop", {8'h0, drop_cnt}, 16'd4);
    cyc(0, 0, 0, 0, 0, 1);
    push_sweep();
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk($sformatf("reflush_sweep_%0d", k), outs(), pk(1, 0, 0, 0, 1, 4'(k), 2'b10));
    end
    cyc(0, 0, 0, 0, 1, 0);
    chk("reflush_done", outs(), pk(0, 1, 0, 0, 0, 0, 0));
    chk("reflush_drop", {8'h0, drop_cnt}, 16'd4);
    chk("reflush_drain", 16'(exp_q.size()), 16'h0);

    // Reset clears the drop counter.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("reset_drop_clear", {8'h0, drop_cnt}, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
